// File: rtl/gbt_rx_frameclk_dps_ctrl.sv
// DPS sequencer for the GBT RX frame-clock PLL: walks the phase_en/updn/cntsel
// handshake one step at a time and tracks phase position modulo one frame period.
module gbt_rx_frameclk_dps_ctrl #(
    parameter int STEP_W           = 8,
    parameter int EN_CYCLES        = 2,
    parameter int TIMEOUT          = 255,
    parameter int STEPS_PER_PERIOD = 144,
    parameter int POS_W            = 8
) (
    input  logic              scanclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              req_up,
    input  logic [4:0]        req_cntsel,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    input  logic              phase_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [POS_W-1:0]  position
);

    typedef enum logic [2:0] {
        IDLE, DONE_Z, SETUP, PULSE, WAIT_LO, WAIT_HI
    } state_t;

    localparam logic [3:0]        EN_LAST  = 4'(EN_CYCLES - 1);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(STEPS_PER_PERIOD - 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t              state, state_d;
    logic                lock_m, lock_s;
    logic [STEP_W-1:0]   remaining, remaining_d;
    logic [3:0]          en_cnt, en_cnt_d;
    logic [15:0]         tmr, tmr_d;
    logic                phase_en_d, updn_d, busy_d, done_d, err_d;
    logic [4:0]          cntsel_d;
    logic [1:0]          err_code_d;
    logic [POS_W-1:0]    position_d, pos_inc, pos_dec;

    // pll_locked is asynchronous to scanclk
    always_ff @(posedge scanclk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    assign req_ready = (state == IDLE) & lock_s;
    assign pos_inc   = (position == POS_MAX) ? '0 : position + POS_W'(1);
    assign pos_dec   = (position == '0) ? POS_MAX : position - POS_W'(1);

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        en_cnt_d    = en_cnt;
        tmr_d       = tmr;
        phase_en_d  = 1'b0;
        updn_d      = updn;
        cntsel_d    = cntsel;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code;
        position_d  = position;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    err_code_d = 2'b00;
                    updn_d     = req_up;
                    cntsel_d   = req_cntsel;
                    if (req_steps == '0) begin
                        state_d = DONE_Z;
                        done_d  = 1'b1;
                    end else begin
                        remaining_d = req_steps;
                        state_d     = SETUP;
                    end
                end
            end
            DONE_Z: state_d = IDLE;
            SETUP: begin
                en_cnt_d   = 4'd0;
                phase_en_d = 1'b1;
                state_d    = PULSE;
            end
            PULSE: begin
                if (en_cnt == EN_LAST) begin
                    tmr_d   = 16'd0;
                    state_d = WAIT_LO;
                end else begin
                    en_cnt_d   = en_cnt + 4'd1;
                    phase_en_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!phase_done) begin
                    tmr_d   = 16'd0;
                    state_d = WAIT_HI;
                end else if (tmr == TMO_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = IDLE;
                end else begin
                    tmr_d = tmr + 16'd1;
                end
            end
            WAIT_HI: begin
                if (phase_done) begin
                    position_d  = updn ? pos_inc : pos_dec;
                    remaining_d = remaining - STEP_ONE;
                    if (remaining == STEP_ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SETUP;
                    end
                end else if (tmr == TMO_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = IDLE;
                end else begin
                    tmr_d = tmr + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Lock loss overrides any timeout or step completion decided above
        if (state != IDLE && !lock_s) begin
            state_d     = IDLE;
            phase_en_d  = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b1;
            err_code_d  = 2'b10;
            position_d  = position;
            remaining_d = remaining;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge scanclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            en_cnt    <= 4'd0;
            tmr       <= 16'd0;
            phase_en  <= 1'b0;
            updn      <= 1'b0;
            cntsel    <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            position  <= '0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            en_cnt    <= en_cnt_d;
            tmr       <= tmr_d;
            phase_en  <= phase_en_d;
            updn      <= updn_d;
            cntsel    <= cntsel_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            err_code  <= err_code_d;
            position  <= position_d;
        end
    end

endmodule

// File: tb/tb_gbt_rx_frameclk_dps_ctrl.sv
// Directed bench for gbt_rx_frameclk_dps_ctrl: a PLL phase_done model, a request
// driver, and a monitor that pops expected completion reports from a queue.
module tb_gbt_rx_frameclk_dps_ctrl;

    localparam int EN = 2;

    logic       scanclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_steps = 8'd0;
    logic       req_up = 1'b0;
    logic [4:0] req_cntsel = 5'd0;
    logic       phase_done = 1'b1;
    logic       req_ready, phase_en, updn, busy, done, err;
    logic [4:0] cntsel;
    logic [1:0] err_code;
    logic [7:0] position;

    // report word: {done, err, err_code, position, updn, cntsel, phase_en pulses}
    logic [25:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit pll_stuck = 1'b0;

    int   pll_t = -1;
    logic pll_prev_en = 1'b0;
    int   pulses = 0;
    int   width = 0;
    logic mon_prev_en = 1'b0;

    gbt_rx_frameclk_dps_ctrl #(
        .STEP_W(8), .EN_CYCLES(EN), .TIMEOUT(16), .STEPS_PER_PERIOD(144), .POS_W(8)
    ) dut (
        .scanclk(scanclk), .rst(rst), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_steps(req_steps),
        .req_up(req_up), .req_cntsel(req_cntsel), .phase_en(phase_en),
        .updn(updn), .cntsel(cntsel), .phase_done(phase_done), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .position(position)
    );

    always #5 scanclk = ~scanclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // PLL model: phase_done drops 2 cycles after phase_en falls, rises 4 later
    initial forever begin
        @(negedge scanclk);
        if (pll_prev_en && !phase_en && !pll_stuck) pll_t = 0;
        else if (pll_t >= 0) pll_t++;
        if (pll_t == 2) phase_done = 1'b0;
        if (pll_t == 6) begin
            phase_done = 1'b1;
            pll_t = -1;
        end
        pll_prev_en = phase_en;
    end

    // Monitor: phase_en pulse widths and done/err reports against the queue
    initial forever begin
        logic [25:0] exp_w, act_w;
        @(negedge scanclk);
        if (rst) begin
            pulses = 0;
        end else if (phase_en && !mon_prev_en) begin
            pulses++;
            width = 1;
        end else if (phase_en) begin
            width++;
        end else if (mon_prev_en && !err) begin
            check("pulse_width", width, EN);
        end
        if (done || err) begin
            act_w = {done, err, err_code, position, updn, cntsel, pulses[7:0]};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_report: got done=%0b err=%0b with nothing expected", done, err);
            end else begin
                exp_w = exp_q.pop_front();
                if (act_w !== exp_w) begin
                    errors++;
                    $display("FAIL report: got done=%0b err=%0b code=%0d pos=%0d updn=%0b cntsel=%0d pulses=%0d expected done=%0b err=%0b code=%0d pos=%0d updn=%0b cntsel=%0d pulses=%0d",
                             act_w[25], act_w[24], act_w[23:22], act_w[21:14], act_w[13], act_w[12:8], act_w[7:0],
                             exp_w[25], exp_w[24], exp_w[23:22], exp_w[21:14], exp_w[13], exp_w[12:8], exp_w[7:0]);
                end
            end
            if (err) check("phase_en_low_on_err", phase_en, 0);
            pulses = 0;
        end
        mon_prev_en = phase_en;
    end

    task automatic push(input logic d, input logic e, input logic [1:0] code, input logic [7:0] pos,
                        input logic up, input logic [4:0] csel, input logic [7:0] np);
        exp_q.push_back({d, e, code, pos, up, csel, np});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge scanclk);
            n++;
        end
        check("ready_wait", req_ready, 1);
    endtask

    // returns at the negedge following the accept edge
    task automatic send(input logic [7:0] steps, input logic up, input logic [4:0] csel);
        wait_ready();
        req_steps  = steps;
        req_up     = up;
        req_cntsel = csel;
        req_valid  = 1'b1;
        @(negedge scanclk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge scanclk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_pos(input logic [7:0] p);
        int n = 0;
        while (position != p && n < 200) begin
            @(negedge scanclk);
            n++;
        end
        check("reach_position", position, p);
    endtask

    initial begin
        int k;
        // reset values
        repeat (2) @(negedge scanclk);
        check("rst_phase_en", phase_en, 0);
        check("rst_busy", busy, 0);
        check("rst_position", position, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_cntsel", cntsel, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;

        // without lock nothing is accepted
        req_valid = 1'b1;
        req_steps = 8'd1;
        for (int i = 0; i < 8; i++) begin
            @(negedge scanclk);
            check("unlocked_ready", req_ready, 0);
            check("unlocked_busy", busy, 0);
        end
        req_valid = 1'b0;

        // req_ready rises on the 2nd edge after lock
        pll_locked = 1'b1;
        @(negedge scanclk);
        check("ready_after_edge1", req_ready, 0);
        @(negedge scanclk);
        check("ready_after_edge2", req_ready, 1);

        // 3 up on counter 0
        push(1, 0, 2'b00, 8'd3, 1, 5'd0, 8'd3);
        send(8'd3, 1'b1, 5'd0);
        check("accept_busy", busy, 1);
        check("accept_updn", updn, 1);
        check("accept_phase_en", phase_en, 0);
        @(negedge scanclk);
        check("edge1_phase_en", phase_en, 1);
        wait_drain();
        @(negedge scanclk);
        check("ready_after_done", req_ready, 1);

        // back to 0, then wrap down to 143 and back up to 0
        push(1, 0, 2'b00, 8'd0, 0, 5'd2, 8'd3);
        send(8'd3, 1'b0, 5'd2);
        wait_drain();
        push(1, 0, 2'b00, 8'd143, 0, 5'd1, 8'd1);
        send(8'd1, 1'b0, 5'd1);
        wait_drain();
        push(1, 0, 2'b00, 8'd0, 1, 5'd1, 8'd1);
        send(8'd1, 1'b1, 5'd1);
        wait_drain();

        // zero-step request
        push(1, 0, 2'b00, 8'd0, 1, 5'd1, 8'd0);
        send(8'd0, 1'b1, 5'd1);
        check("zero_done_next_cycle", done, 1);
        wait_drain();

        // timeout: phase_done never drops
        pll_stuck = 1'b1;
        push(0, 1, 2'b01, 8'd0, 1, 5'd3, 8'd1);
        send(8'd2, 1'b1, 5'd3);
        k = 0;
        while (!phase_en && k < 20) begin @(negedge scanclk); k++; end
        while (phase_en && k < 40) begin @(negedge scanclk); k++; end
        k = 0;
        while (!err && k < 40) begin @(negedge scanclk); k++; end
        check("timeout_cycles", k, 16);
        wait_drain();
        repeat (3) @(negedge scanclk);
        check("timeout_code_held", err_code, 1);
        check("timeout_busy", busy, 0);
        pll_stuck = 1'b0;

        // lock loss after 2 of 5 steps; a busy-time request is ignored
        push(0, 1, 2'b10, 8'd2, 1, 5'd4, 8'd3);
        send(8'd5, 1'b1, 5'd4);
        check("accept_clears_code", err_code, 0);
        repeat (2) @(negedge scanclk);
        req_steps  = 8'd1;
        req_up     = 1'b0;
        req_cntsel = 5'd9;
        req_valid  = 1'b1;
        @(negedge scanclk);
        req_valid  = 1'b0;
        check("busy_req_cntsel", cntsel, 4);
        wait_pos(8'd2);
        pll_locked = 1'b0;
        k = 0;
        while (!err && k < 3) begin @(negedge scanclk); k++; end
        check("lockloss_err_within_3", err, 1);
        wait_drain();
        repeat (3) @(negedge scanclk);
        check("lockloss_code_held", err_code, 2);
        check("lockloss_position", position, 2);
        check("lockloss_ready", req_ready, 0);

        // asynchronous reset mid-request
        pll_locked = 1'b1;
        send(8'd2, 1'b1, 5'd6);
        wait_pos(8'd3);
        rst = 1'b1;
        #1;
        check("midrst_position", position, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cntsel", cntsel, 0);
        check("midrst_updn", updn, 0);
        check("midrst_phase_en", phase_en, 0);
        check("midrst_ready", req_ready, 0);
        repeat (3) @(negedge scanclk);
        rst = 1'b0;
        repeat (3) @(negedge scanclk);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gbt_rx_frameclk_dps_ctrl.md
# gbt_rx_frameclk_dps_ctrl

Dynamic-phase-shift (DPS) sequencer for the GBT RX frame-clock phase-aligner PLL: it accepts "shift N steps up/down on counter C" requests and drives the PLL's `phase_en`/`updn`/`cntsel` interface, one step at a time, handshaking on `phase_done`. It tracks the resulting phase position modulo one frame-clock period and aborts cleanly on PLL lock loss or a stalled handshake. It sits between the phase-aligner control logic and the PLL, clocked by the PLL `scanclk`.

## Interface
Parameters:
- `STEP_W`, 8: width of the request step count.
- `EN_CYCLES`, 2: `phase_en` pulse width in `scanclk` cycles (1..15).
- `TIMEOUT`, 255: max cycles spent waiting for each `phase_done` edge (1..65535).
- `STEPS_PER_PERIOD`, 144: DPS steps per frame-clock period (720 MHz VCO / 40 MHz out × 8).
- `POS_W`, 8: width of `position` (must hold `STEPS_PER_PERIOD-1`).

Ports:
- `scanclk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`, asynchronous.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_steps` in STEP_W: number of steps.
- `req_up` in 1: 1 = shift later (updn=1), 0 = earlier.
- `req_cntsel` in 5: PLL counter select.
- `phase_en` out 1: to PLL.
- `updn` out 1: to PLL.
- `cntsel` out 5: to PLL.
- `phase_done` in 1: from PLL, synchronous to `scanclk`.
- `busy` out 1: request in progress.
- `done` out 1: one-cycle pulse, request completed.
- `err` out 1: one-cycle pulse, request aborted.
- `err_code` out 2: 01 timeout, 10 lock lost; held until next accept.
- `position` out POS_W: current phase position, 0..STEPS_PER_PERIOD-1.

## Operation
- `pll_locked` passes through a 2-flop synchronizer → `lock_s`.
- `req_ready = (state==IDLE) & lock_s`. Request fields are registered on accept; inputs ignored otherwise.
- States:
  - IDLE: on accept with `req_steps==0` → DONE_Z; else load `remaining=req_steps`, drive `cntsel`/`updn` → SETUP.
  - DONE_Z: pulse `done`, → IDLE.
  - SETUP: one cycle, `cntsel`/`updn` stable, `phase_en=0` → PULSE.
  - PULSE: `phase_en=1` for exactly EN_CYCLES cycles → WAIT_LO.
  - WAIT_LO: wait `phase_done==0` → WAIT_HI.
  - WAIT_HI: wait `phase_done==1`; then `position` ±1 with wrap (up: STEPS_PER_PERIOD-1→0; down: 0→STEPS_PER_PERIOD-1), `remaining-=1`. If `remaining` becomes 0 → pulse `done`, → IDLE; else → SETUP.
- Timeout: a cycle counter is reset on entry to WAIT_LO/WAIT_HI; after TIMEOUT cycles without the awaited level → abort, `err_code=01`; `position` not updated for that step.
- Lock loss: `lock_s==0` in any state other than IDLE → abort, `err_code=10`. Takes priority over timeout and step completion in the same cycle.
- Abort: `phase_en=0`, pulse `err`, → IDLE. Completed steps remain in `position`.
- `cntsel`/`updn` hold their last values in IDLE.
- `busy=1` in every state except IDLE.

## Timing
- Reset values: `phase_en=0`, `updn=0`, `cntsel=0`, `busy=0`, `done=0`, `err=0`, `err_code=0`, `position=0`, `req_ready=0`, state IDLE, `lock_s=0`.
- `req_ready` rises on the 2nd `scanclk` edge after `pll_locked` rises, with the FSM in IDLE.
- Accept at edge 0: `busy`, `cntsel`, `updn` valid after edge 0 (SETUP). `phase_en` high after edges 1..EN_CYCLES, low after edge EN_CYCLES+1.
- Step completes on the edge sampling `phase_done==1` in WAIT_HI. On the last step, `done` and the final `position` are visible after that edge, and `req_ready` is high the next cycle.
- Zero-step request: `done` is high for the cycle after the accept edge.
- All outputs are registered, except `req_ready`, which is decoded from registers only.
- Asserting `rst` mid-operation returns every output to its reset value immediately, including `position`.

## Test plan
- Reset, then `pll_locked`=1 → `req_ready`=1 after the 2nd edge. Keep `pll_locked`=0 → `req_valid` is never accepted.
- Request 3 up, cntsel=0. PLL model drops `phase_done` 2 cycles after `phase_en` falls, raises it 4 cycles later → 3 `phase_en` pulses of 2 cycles each, `updn`=1, `position` 0→1→2→3, one `done` pulse, `err`=0.
- From position 0, request 1 down → `updn`=0, `position`=143. Then request 1 up → `position`=0.
- Request 0 steps → `done` pulse one cycle after accept, no `phase_en`, `position` unchanged.
- TIMEOUT=16, model never drops `phase_done` → `err` pulse 16 cycles after WAIT_LO entry, `err_code`=01, `position` unchanged, `phase_en`=0.
- Request 5 steps, drop `pll_locked` after step 2 completes → `err` pulse within 3 cycles, `err_code`=10, `position`=2. `req_valid` pulsed while busy in this run is ignored.
